// File: rtl/dma_dccm_req_if.sv
// DMA-side request/response channel for dma_dccm_req.
interface dma_dccm_req_if #(
   parameter int unsigned DCCM_BITS = 16,
   parameter int unsigned DATA_W    = 32
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [DCCM_BITS-1:0] req_addr;
   logic [1:0]           req_size;
   logic [DATA_W-1:0]    req_wdata;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [DATA_W-1:0]    rsp_rdata;
   logic                 rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dma_dccm_req.sv
// Single-outstanding DMA access engine into the DCCM bank (reads, word writes, sub-word RMW).
// Define RV_DMA_DCCM_SUBWORD_EN to enable sub-word writes via read-modify-write; otherwise they are rejected.
module dma_dccm_req #(
   parameter int unsigned DCCM_BITS = 16,
   parameter int unsigned DATA_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst_l,
   dma_dccm_req_if.slave        dma,
   output logic                 dccm_req,
   input  logic                 dccm_gnt,
   output logic                 dccm_rden,
   output logic                 dccm_wren,
   output logic [DCCM_BITS-1:0] dccm_rd_addr_lo,
   output logic [DCCM_BITS-1:0] dccm_rd_addr_hi,
   output logic [DCCM_BITS-1:0] dccm_wr_addr,
   output logic [DATA_W-1:0]    dccm_wr_data,
   input  logic [DATA_W-1:0]    dccm_rd_data_lo
);

   localparam int unsigned SH_W = 5;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      RDATA = 3'd2,
      WR    = 3'd3,
      RSP   = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [DCCM_BITS-1:0] addr_q;
   logic [1:0]           size_q;
   logic                 write_q;
   logic [DATA_W-1:0]    wr_data_q;
   logic [DATA_W-1:0]    rsp_rdata_q;
   logic                 rsp_err_q;

   logic              accept;
   logic              reject;
   logic              rsp_done;
   logic [SH_W-1:0]   lane_sh;
   logic [DATA_W-1:0] rd_shift;
   logic [DATA_W-1:0] rd_lane;
   logic [DATA_W-1:0] lane_mask;
   logic [DATA_W-1:0] merged;

   // Request legality: misalignment and size 3 always reject; sub-word writes only with RMW support
   always_comb begin
      reject = 1'b0;
      if (dma.req_size == 2'd3)
         reject = 1'b1;
      if ((dma.req_size == 2'd1) && dma.req_addr[0])
         reject = 1'b1;
      if ((dma.req_size == 2'd2) && (dma.req_addr[1:0] != 2'b00))
         reject = 1'b1;
`ifndef RV_DMA_DCCM_SUBWORD_EN
      if (dma.req_write && !dma.req_size[1])
         reject = 1'b1;
`endif
   end

   // Lane extraction for reads and byte-merge for sub-word writes
   assign lane_sh  = {addr_q[1:0], 3'b000};
   assign rd_shift = dccm_rd_data_lo >> lane_sh;

   always_comb begin
      rd_lane   = rd_shift;
      lane_mask = '1;
      case (size_q)
         2'd0: begin
            rd_lane   = DATA_W'(rd_shift[7:0]);
            lane_mask = DATA_W'(8'hFF) << lane_sh;
         end
         2'd1: begin
            rd_lane   = DATA_W'(rd_shift[15:0]);
            lane_mask = DATA_W'(16'hFFFF) << lane_sh;
         end
         default: ;
      endcase
   end

   assign merged = (dccm_rd_data_lo & ~lane_mask) | ((wr_data_q << lane_sh) & lane_mask);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      rsp_done  = 1'b0;
      case (state)
         IDLE: begin
            if (dma.req_valid) begin
               accept = 1'b1;
               if (reject)
                  state_nxt = RSP;
               else if (dma.req_write && (dma.req_size == 2'd2))
                  state_nxt = WR;
               else
                  state_nxt = RD;
            end
         end
         RD:    if (dccm_gnt) state_nxt = RDATA;
         RDATA: state_nxt = write_q ? WR : RSP;
         WR:    if (dccm_gnt) state_nxt = RSP;
         RSP: begin
            if (dma.rsp_ready) begin
               rsp_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture, read-lane / merge capture, and response hold
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         addr_q      <= '0;
         size_q      <= 2'd0;
         write_q     <= 1'b0;
         wr_data_q   <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         if (accept) begin
            addr_q      <= dma.req_addr;
            size_q      <= dma.req_size;
            write_q     <= dma.req_write;
            wr_data_q   <= dma.req_wdata;
            rsp_rdata_q <= '0;
            rsp_err_q   <= reject;
         end
         if (state == RDATA) begin
            if (write_q)
               wr_data_q <= merged;
            else
               rsp_rdata_q <= rd_lane;
         end
         if (rsp_done) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
         end
      end
   end

   assign dma.req_ready = (state == IDLE);
   assign dma.rsp_valid = (state == RSP);
   assign dma.rsp_rdata = rsp_rdata_q;
   assign dma.rsp_err   = rsp_err_q;

   assign dccm_req  = (state == RD) || (state == WR);
   assign dccm_rden = (state == RD) && dccm_gnt;
   assign dccm_wren = (state == WR) && dccm_gnt;

   assign dccm_rd_addr_lo = {addr_q[DCCM_BITS-1:2], 2'b00};
   assign dccm_rd_addr_hi = {addr_q[DCCM_BITS-1:2], 2'b00};
   assign dccm_wr_addr    = {addr_q[DCCM_BITS-1:2], 2'b00};
   assign dccm_wr_data    = wr_data_q;

endmodule

// File: tb/tb_dma_dccm_req.sv
// Directed bench for dma_dccm_req with a response scoreboard and a small DCCM bank model.
module tb_dma_dccm_req;
   localparam int unsigned DCCM_BITS = 16;
   localparam int unsigned DATA_W    = 32;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          nrd;
      int          nwr;
      logic [15:0] addr;
      logic [31:0] wdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst_l = 1'b0;
   always #5 clk = ~clk;

   dma_dccm_req_if #(.DCCM_BITS(DCCM_BITS), .DATA_W(DATA_W)) bus ();

   logic                 dccm_req, dccm_gnt, dccm_rden, dccm_wren;
   logic [DCCM_BITS-1:0] dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr;
   logic [DATA_W-1:0]    dccm_wr_data, dccm_rd_data_lo;

   dma_dccm_req #(.DCCM_BITS(DCCM_BITS), .DATA_W(DATA_W)) dut (
      .clk             (clk),
      .rst_l           (rst_l),
      .dma             (bus.slave),
      .dccm_req        (dccm_req),
      .dccm_gnt        (dccm_gnt),
      .dccm_rden       (dccm_rden),
      .dccm_wren       (dccm_wren),
      .dccm_rd_addr_lo (dccm_rd_addr_lo),
      .dccm_rd_addr_hi (dccm_rd_addr_hi),
      .dccm_wr_addr    (dccm_wr_addr),
      .dccm_wr_data    (dccm_wr_data),
      .dccm_rd_data_lo (dccm_rd_data_lo)
   );

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   // DCCM bank: read data one cycle after a granted rden
   logic [31:0] mem [0:255];
   logic        pl_we = 1'b0;
   logic [7:0]  pl_idx = 8'd0;
   logic [31:0] pl_data = 32'd0;
   always @(posedge clk) begin
      if (pl_we)     mem[pl_idx] <= pl_data;
      if (dccm_rden) dccm_rd_data_lo <= mem[dccm_rd_addr_lo[9:2]];
      if (dccm_wren) mem[dccm_wr_addr[9:2]] <= dccm_wr_data;
   end

   int          rd_cnt = 0, wr_cnt = 0, rsp_cycles = 0;
   logic [15:0] last_rd_lo = '0, last_rd_hi = '0, last_wr_addr = '0;
   logic [31:0] last_wr_data = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Bank-side monitor, sampled mid-cycle
   always begin
      @(negedge clk);
      #1;
      if (dccm_rden || dccm_wren)
         chk("rden_wren_exclusive", 32'(dccm_rden & dccm_wren), 32'd0);
      if (dccm_rden) begin
         rd_cnt++;
         last_rd_lo = dccm_rd_addr_lo;
         last_rd_hi = dccm_rd_addr_hi;
      end
      if (dccm_wren) begin
         wr_cnt++;
         last_wr_addr = dccm_wr_addr;
         last_wr_data = dccm_wr_data;
      end
      if (bus.rsp_valid) rsp_cycles++;
   end

   function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                               input int nrd, input int nwr, input logic [15:0] addr,
                               input logic [31:0] wdata);
      exp_t e;
      e.rdata = rdata; e.err = err; e.lat = lat; e.nrd = nrd; e.nwr = nwr;
      e.addr = addr; e.wdata = wdata;
      return e;
   endfunction

   task automatic preload(input logic [7:0] idx, input logic [31:0] data);
      pl_we = 1'b1; pl_idx = idx; pl_data = data;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic issue(input string tag, input logic wr, input logic [15:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input int gnt_hold, input int rsp_hold, input exp_t e);
      int   rd0, wr0, lat;
      exp_t got;
      sb.push_back(e);
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      dccm_gnt = (gnt_hold == 0);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_size  = size;
      bus.req_wdata = wdata;
      chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      for (int i = 0; i < gnt_hold; i++) begin
         chk({tag, "_stall_req"}, {31'd0, dccm_req}, 32'd1);
         @(negedge clk);
         lat++;
      end
      dccm_gnt = 1'b1;
      while (!bus.rsp_valid && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      got = sb.pop_front();
      chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      chk({tag, "_latency"}, 32'(lat), 32'(got.lat));
      chk({tag, "_rdata"}, bus.rsp_rdata, got.rdata);
      chk({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, got.err});
      for (int i = 0; i < rsp_hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
         chk({tag, "_hold_rdata"}, bus.rsp_rdata, got.rdata);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk({tag, "_rsp_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
      chk({tag, "_nrd"}, 32'(rd_cnt - rd0), 32'(got.nrd));
      chk({tag, "_nwr"}, 32'(wr_cnt - wr0), 32'(got.nwr));
      if (got.nrd > 0) begin
         chk({tag, "_rd_addr_lo"}, 32'(last_rd_lo), 32'(got.addr));
         chk({tag, "_rd_addr_hi"}, 32'(last_rd_hi), 32'(got.addr));
      end
      if (got.nwr > 0) begin
         chk({tag, "_wr_addr"}, 32'(last_wr_addr), 32'(got.addr));
         chk({tag, "_wr_data"}, last_wr_data, got.wdata);
      end
   endtask

   initial begin
      int rd0, rs0;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
      bus.req_size = 2'd0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
      dccm_gnt = 1'b1;

      // Reset state
      preload(8'h40, 32'h1122_3344);
      preload(8'h41, 32'hCAFE_F00D);
      preload(8'h42, 32'h0000_0000);
      chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_dccm_en",   {29'd0, dccm_req, dccm_rden, dccm_wren}, 32'd0);
      chk("rst_wr_addr",   32'(dccm_wr_addr), 32'd0);
      chk("rst_wr_data",   dccm_wr_data, 32'd0);
      rst_l = 1'b1;
      @(negedge clk);

      // Reads of every size and lane
      issue("rd_b103", 1'b0, 16'h0103, 2'd0, 32'd0, 0, 0, mk(32'h0000_0011, 1'b0, 3, 1, 0, 16'h0100, 32'd0));
      issue("rd_h102", 1'b0, 16'h0102, 2'd1, 32'd0, 0, 0, mk(32'h0000_1122, 1'b0, 3, 1, 0, 16'h0100, 32'd0));
      issue("rd_b100", 1'b0, 16'h0100, 2'd0, 32'd0, 0, 0, mk(32'h0000_0044, 1'b0, 3, 1, 0, 16'h0100, 32'd0));
      issue("rd_w100", 1'b0, 16'h0100, 2'd2, 32'd0, 0, 0, mk(32'h1122_3344, 1'b0, 3, 1, 0, 16'h0100, 32'd0));

      // Sub-word writes
`ifdef RV_DMA_DCCM_SUBWORD_EN
      issue("wr_h102", 1'b1, 16'h0102, 2'd1, 32'h0000_ABCD, 0, 0, mk(32'd0, 1'b0, 4, 1, 1, 16'h0100, 32'hABCD_3344));
      chk("mem_after_h102", mem[8'h40], 32'hABCD_3344);
`else
      issue("wr_h102", 1'b1, 16'h0102, 2'd1, 32'h0000_ABCD, 0, 0, mk(32'd0, 1'b1, 1, 0, 0, 16'h0100, 32'd0));
      chk("mem_after_h102", mem[8'h40], 32'h1122_3344);
`endif

      issue("wr_w100", 1'b1, 16'h0100, 2'd2, 32'hDEAD_BEEF, 0, 0, mk(32'd0, 1'b0, 2, 0, 1, 16'h0100, 32'hDEAD_BEEF));
      chk("mem_after_w100", mem[8'h40], 32'hDEAD_BEEF);

`ifdef RV_DMA_DCCM_SUBWORD_EN
      issue("wr_b101", 1'b1, 16'h0101, 2'd0, 32'h0000_00A5, 0, 0, mk(32'd0, 1'b0, 4, 1, 1, 16'h0100, 32'hDEAD_A5EF));
      chk("mem_after_b101", mem[8'h40], 32'hDEAD_A5EF);
`else
      issue("wr_b101", 1'b1, 16'h0101, 2'd0, 32'h0000_00A5, 0, 0, mk(32'd0, 1'b1, 1, 0, 0, 16'h0100, 32'd0));
      chk("mem_after_b101", mem[8'h40], 32'hDEAD_BEEF);
`endif

      // Illegal requests: misaligned and size 3
      issue("rd_w102_mis", 1'b0, 16'h0102, 2'd2, 32'd0, 0, 0, mk(32'd0, 1'b1, 1, 0, 0, 16'h0100, 32'd0));
      issue("rd_sz3",      1'b0, 16'h0100, 2'd3, 32'd0, 0, 0, mk(32'd0, 1'b1, 1, 0, 0, 16'h0100, 32'd0));
      issue("rd_h101_mis", 1'b0, 16'h0101, 2'd1, 32'd0, 0, 0, mk(32'd0, 1'b1, 1, 0, 0, 16'h0100, 32'd0));
      issue("wr_w10a_mis", 1'b1, 16'h010A, 2'd2, 32'h1234_5678, 0, 0, mk(32'd0, 1'b1, 1, 0, 0, 16'h0108, 32'd0));

      // Arbiter stalls and response back-pressure
      issue("rd_stall", 1'b0, 16'h0104, 2'd2, 32'd0, 5, 3, mk(32'hCAFE_F00D, 1'b0, 8, 1, 0, 16'h0104, 32'd0));
      issue("wr_stall", 1'b1, 16'h0108, 2'd2, 32'h1234_5678, 2, 1, mk(32'd0, 1'b0, 4, 0, 1, 16'h0108, 32'h1234_5678));
      chk("mem_after_wr_stall", mem[8'h42], 32'h1234_5678);

      // Reset while waiting for grant in RD
      dccm_gnt = 1'b0;
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'h0104; bus.req_size = 2'd2;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("midrst_in_rd", {31'd0, dccm_req}, 32'd1);
      rd0 = rd_cnt;
      rs0 = rsp_cycles;
      @(negedge clk);
      rst_l = 1'b0;
      #1;
      chk("midrst_dccm_req", {31'd0, dccm_req}, 32'd0);
      chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("midrst_rd_addr", 32'(dccm_rd_addr_lo), 32'd0);
      @(negedge clk);
      rst_l = 1'b1;
      dccm_gnt = 1'b1;
      repeat (4) @(negedge clk);
      chk("midrst_no_rden", 32'(rd_cnt - rd0), 32'd0);
      chk("midrst_no_rsp", 32'(rsp_cycles - rs0), 32'd0);
      chk("midrst_idle", {31'd0, bus.req_ready}, 32'd1);

      // Engine still usable after the abandoned request
      issue("rd_after_rst", 1'b0, 16'h0107, 2'd0, 32'd0, 0, 0, mk(32'h0000_00CA, 1'b0, 3, 1, 0, 16'h0104, 32'd0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
